// File: rtl/cu_pkg.sv
// Shared types for the multicycle control unit: FSM states, opcode map,
// ALUOp encodings and the per-state control decode.
package cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [3:0] OP_R_HI = 4'h2;
    localparam logic [3:0] OP_I_LO = 4'h9;
    localparam logic [3:0] OP_I_HI = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;
    localparam logic [3:0] OP_BEQ  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RFN = 2'b10;
    localparam logic [1:0] ALU_IOP = 2'b11;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL
    } op_class_e;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] aluop;
        logic       branch;
        logic       fetch;
        logic       iord;
        logic       trap;
    } ctrl_t;

    function automatic op_class_e classify(logic [3:0] op);
        op_class_e c;
        unique case (1'b1)
            (op <= OP_R_HI):                   c = C_R;
            (op >= OP_I_LO && op <= OP_I_HI):  c = C_I;
            (op == OP_LW):                     c = C_LW;
            (op == OP_SW):                     c = C_SW;
            (op == OP_BEQ):                    c = C_BEQ;
            default:                           c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic ctrl_t decode_ctrl(state_e st, op_class_e cls);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.memread = 1'b1;
                c.fetch   = 1'b1;
            end
            S_EXEC: begin
                c.regdst = (cls == C_R);
                c.alusrc = cls inside {C_I, C_LW, C_SW};
                c.branch = (cls == C_BEQ);
                case (cls)
                    C_R:     c.aluop = ALU_RFN;
                    C_I:     c.aluop = ALU_IOP;
                    C_BEQ:   c.aluop = ALU_SUB;
                    default: c.aluop = ALU_ADD;
                endcase
            end
            S_MEM: begin
                c.iord     = 1'b1;
                c.memread  = (cls == C_LW);
                c.memwrite = (cls == C_SW);
            end
            S_WB: begin
                c.regwrite = 1'b1;
                c.regdst   = (cls == C_R);
                c.memtoreg = (cls == C_LW);
            end
            S_TRAP: c.trap = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cu_timeout_counter.sv
// Counts consecutive memory wait cycles and flags the last one allowed
// before a timeout; MEM_TIMEOUT of 0 disables the flag.
module cu_timeout_counter #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    assign hit_o = (MEM_TIMEOUT != 0) && inc_i && (count_q == LIMIT);

    // Saturates so a disabled timeout never wraps back through zero.
    always_comb begin
        count_d = count_q;
        if (clr_i || hit_o) begin
            count_d = '0;
        end else if (inc_i && count_q != '1) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle Moore control FSM: FETCH/DECODE/EXEC/MEM/WB with memory
// ready stalls, illegal-opcode and memory-timeout traps.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                Clock_i,
    input  logic                Reset_i,
    input  logic [OPCODE_W-1:0] OPCode_i,
    input  logic                MemReady_i,
    output logic                RegDst_o,
    output logic                ALUSrc_o,
    output logic                MemToReg_o,
    output logic                RegWrite_o,
    output logic                MemRead_o,
    output logic                MemWrite_o,
    output logic [ALUOP_W-1:0]  ALUOp_o,
    output logic                Branch_o,
    output logic                PCWrite_o,
    output logic                IRWrite_o,
    output logic                IorD_o,
    output logic                Trap_o
);

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    ctrl_t      ctrl_q;
    op_class_e  cls_q;
    logic       wait_st;
    logic       tmo_hit;
    logic       op_legal;

    assign cls_q   = classify(opcode_q);
    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);

    assign op_legal = (OPCode_i == OPCODE_W'(OPCode_i[3:0]))
                   && (classify(OPCode_i[3:0]) != C_ILL);

    cu_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_tmo (
        .clk_i(Clock_i),
        .rst_i(Reset_i),
        .clr_i(!wait_st || MemReady_i),
        .inc_i(wait_st && !MemReady_i),
        .hit_o(tmo_hit)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (MemReady_i) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                opcode_d = OPCode_i[3:0];
                state_d  = op_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                unique case (cls_q)
                    C_R, C_I:   state_d = S_WB;
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ:      state_d = S_FETCH;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (MemReady_i) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Controls are registered from the next state so they line up with state_q.
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ctrl_q   <= decode_ctrl(state_d, classify(opcode_d));
        end
    end

    assign RegDst_o   = ctrl_q.regdst;
    assign ALUSrc_o   = ctrl_q.alusrc;
    assign MemToReg_o = ctrl_q.memtoreg;
    assign RegWrite_o = ctrl_q.regwrite;
    assign MemRead_o  = ctrl_q.memread;
    assign MemWrite_o = ctrl_q.memwrite;
    assign ALUOp_o    = ALUOP_W'(ctrl_q.aluop);
    assign Branch_o   = ctrl_q.branch;
    assign IorD_o     = ctrl_q.iord;
    assign Trap_o     = ctrl_q.trap;

    // IR load and PC advance commit only on the cycle memory delivers the word.
    assign IRWrite_o  = ctrl_q.fetch & MemReady_i;
    assign PCWrite_o  = ctrl_q.fetch & MemReady_i;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected control timelines built
// from the opcode, fetch wait and memory wait counts.
module tb_multicycle_control_unit;

    localparam int TMO = 4;

    localparam logic [12:0] REGDST   = 13'h0001;
    localparam logic [12:0] ALUSRC   = 13'h0002;
    localparam logic [12:0] MEMTOREG = 13'h0004;
    localparam logic [12:0] REGWRITE = 13'h0008;
    localparam logic [12:0] MEMREAD  = 13'h0010;
    localparam logic [12:0] MEMWRITE = 13'h0020;
    localparam logic [12:0] ALU_SUB  = 13'h0040;
    localparam logic [12:0] ALU_RFN  = 13'h0080;
    localparam logic [12:0] ALU_IOP  = 13'h00C0;
    localparam logic [12:0] BRANCH   = 13'h0100;
    localparam logic [12:0] PCWRITE  = 13'h0200;
    localparam logic [12:0] IRWRITE  = 13'h0400;
    localparam logic [12:0] IORD     = 13'h0800;
    localparam logic [12:0] TRAP     = 13'h1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [3:0] opc;
    logic       rdst, asrc, m2r, rw, mr, mw, br, pcw, irw, iord, trap;
    logic [1:0] aluop;
    logic [12:0] obs;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OPCODE_W(4),
        .ALUOP_W(2),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .Clock_i(clk),
        .Reset_i(rst),
        .OPCode_i(opc),
        .MemReady_i(rdy),
        .RegDst_o(rdst),
        .ALUSrc_o(asrc),
        .MemToReg_o(m2r),
        .RegWrite_o(rw),
        .MemRead_o(mr),
        .MemWrite_o(mw),
        .ALUOp_o(aluop),
        .Branch_o(br),
        .PCWrite_o(pcw),
        .IRWrite_o(irw),
        .IorD_o(iord),
        .Trap_o(trap)
    );

    assign obs = {trap, iord, irw, pcw, br, aluop, mw, mr, rw, m2r, asrc, rdst};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        r;
        logic [3:0]  o;
        logic [12:0] e;
        string       tag;
    } cyc_t;

    cyc_t plan[$];

    function automatic logic [3:0] junk();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic r, input logic [3:0] o,
                                 input logic [12:0] e, input string tag);
        cyc_t c;
        c.r = r;
        c.o = o;
        c.e = e;
        c.tag = tag;
        plan.push_back(c);
    endfunction

    function automatic void trap_tail(input int n);
        for (int i = 0; i < n; i++) push(coin(), junk(), TRAP, "trap");
    endfunction

    task automatic step(input logic r, input logic [3:0] o,
                        input logic [12:0] e, input string tag);
        rdy = r;
        opc = o;
        @(negedge clk);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run();
        cyc_t c;
        while (plan.size() != 0) begin
            c = plan.pop_front();
            step(c.r, c.o, c.e, c.tag);
        end
    endtask

    // Expected cycle-by-cycle controls of one instruction, FETCH to last cycle.
    task automatic expand(input logic [3:0] op, input int fw, input int mw,
                          output bit trapped);
        bit is_r, is_i, is_lw, is_sw, is_beq;
        logic [12:0] macc;
        trapped = 1'b0;
        is_r   = (op <= 4'h2);
        is_i   = (op >= 4'h9) && (op <= 4'hB);
        is_lw  = (op == 4'hC);
        is_sw  = (op == 4'hD);
        is_beq = (op == 4'hF);
        for (int i = 0; i < fw && i < TMO; i++) push(1'b0, junk(), MEMREAD, "fetch_wait");
        if (fw >= TMO) begin
            trap_tail(4);
            trapped = 1'b1;
            return;
        end
        push(1'b1, junk(), MEMREAD | IRWRITE | PCWRITE, "fetch");
        push(coin(), op, 13'h0, "decode");
        if (!(is_r || is_i || is_lw || is_sw || is_beq)) begin
            trap_tail(10);
            trapped = 1'b1;
            return;
        end
        if (is_r) begin
            push(coin(), junk(), REGDST | ALU_RFN, "exec_r");
            push(coin(), junk(), REGWRITE | REGDST, "wb_r");
        end else if (is_i) begin
            push(coin(), junk(), ALUSRC | ALU_IOP, "exec_i");
            push(coin(), junk(), REGWRITE, "wb_i");
        end else if (is_beq) begin
            push(coin(), junk(), BRANCH | ALU_SUB, "exec_beq");
        end else begin
            push(coin(), junk(), ALUSRC, "exec_mem");
            macc = IORD | (is_lw ? MEMREAD : MEMWRITE);
            for (int i = 0; i < mw && i < TMO; i++) push(1'b0, junk(), macc, "mem_wait");
            if (mw >= TMO) begin
                trap_tail(4);
                trapped = 1'b1;
                return;
            end
            push(1'b1, junk(), macc, "mem");
            if (is_lw) push(coin(), junk(), REGWRITE | MEMTOREG, "wb_lw");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(coin(), junk(), TRAP, "trap_at_rst");
        step(coin(), junk(), 13'h0, "rst");
        rst = 1'b0;
        step(coin(), junk(), 13'h0, "idle");
    endtask

    logic [3:0] legal [9] = '{4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};

    initial begin
        bit t;
        cyc_t c;
        logic [3:0] op;
        int fw, mw;

        rst = 1'b1;
        rdy = 1'b1;
        opc = 4'h1;
        @(posedge clk);
        #1;
        step(1'b1, 4'h1, 13'h0, "reset");
        step(1'b1, 4'h1, 13'h0, "reset");
        rst = 1'b0;
        step(1'b1, 4'h1, 13'h0, "idle");

        expand(4'h1, 0, 0, t); run();
        expand(4'hC, 0, 2, t); run();
        expand(4'hD, 0, 0, t); expand(4'hF, 0, 0, t); run();

        expand(4'h6, 0, 0, t); run(); do_reset();
        expand(4'h1, 6, 0, t); run(); do_reset();
        expand(4'h9, 3, 0, t); run();
        expand(4'hC, 0, 3, t); run();
        expand(4'hD, 0, 4, t); run(); do_reset();

        // Reset lands while SW is stalled in MEM with MemWrite asserted.
        expand(4'hD, 0, 2, t);
        repeat (3) begin
            c = plan.pop_front();
            step(c.r, c.o, c.e, c.tag);
        end
        rst = 1'b1;
        c = plan.pop_front();
        step(c.r, c.o, c.e, c.tag);
        plan.delete();
        step(coin(), junk(), 13'h0, "rst_mid_mem");
        rst = 1'b0;
        step(coin(), junk(), 13'h0, "idle");

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? junk() : legal[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 3));
            expand(op, fw, mw, t);
            run();
            if (t) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
